alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared combinational ALU: accept one op,
// drive the ALU for one cycle, park the result in the winner's response register.

module alu_arb_rsp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap,
    input  logic        ready,
    input  logic [31:0] res_d,
    input  logic        less_d,
    input  logic        zero_d,
    output logic        valid,
    output logic [31:0] result,
    output logic        less,
    output logic        zero
);
    // Capture wins over a same-edge ready: valid was low while the op executed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            result <= '0;
            less   <= 1'b0;
            zero   <= 1'b0;
        end else if (cap) begin
            valid  <= 1'b1;
            result <= res_d;
            less   <= less_d;
            zero   <= zero_d;
        end else if (valid && ready) begin
            valid  <= 1'b0;
        end
    end
endmodule

module alu_arbiter #(
    parameter bit RR_EN     = 1'b1,
    parameter bit LESS_MASK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_ctr,
    input  logic        req0_ext,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_less,
    output logic        rsp0_zero,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_ctr,
    input  logic        req1_ext,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_less,
    output logic        rsp1_zero,
    output logic [31:0] alu_dataa,
    output logic [31:0] alu_datab,
    output logic [2:0]  alu_ctr,
    output logic        alu_ext,
    input  logic [31:0] alu_result,
    input  logic        alu_less,
    input  logic        alu_zero,
    output logic        busy
);
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctr;
        logic        ext;
    } alu_op_t;

    alu_op_t [1:0]        req_op;
    alu_op_t              op_q;
    logic [0:0]           state;
    logic                 owner;
    logic                 last_grant;
    logic [1:0]           qv, rdy, free, elig, acc, cap, rrdy, rv, rl, rz;
    logic [1:0][31:0]     rres;
    logic                 pick1;
    logic                 less_cap;

    assign req_op[0] = {req0_a, req0_b, req0_ctr, req0_ext};
    assign req_op[1] = {req1_a, req1_b, req1_ctr, req1_ext};
    assign qv        = {req1_valid, req0_valid};
    assign rrdy      = {rsp1_ready, rsp0_ready};

    assign busy = (state == EXEC);
    assign free = (state == IDLE) ? ~rv : 2'b00;
    assign elig = free & qv;

    // Tie-break used only when both ports are eligible.
    assign pick1  = RR_EN ? (last_grant == 1'b0) : 1'b0;
    assign rdy[0] = free[0] && !(elig[1] && pick1);
    assign rdy[1] = free[1] && !(elig[0] && !pick1);
    assign acc    = qv & rdy;

    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= '{a: 32'd0, b: 32'd0, ctr: ALU_ADD, ext: 1'b0};
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (state == EXEC) begin
            state <= IDLE;
        end else if (|acc) begin
            op_q       <= req_op[acc[1]];
            owner      <= acc[1];
            last_grant <= acc[1];
            state      <= EXEC;
        end
    end

    assign alu_dataa = op_q.a;
    assign alu_datab = op_q.b;
    assign alu_ctr   = op_q.ctr;
    assign alu_ext   = op_q.ext;

    assign less_cap = (LESS_MASK && op_q.ctr != ALU_SLT && op_q.ctr != ALU_SLTU)
                      ? 1'b0 : alu_less;

    for (genvar g = 0; g < 2; g++) begin : g_rsp
        assign cap[g] = busy && (owner == 1'(g));
        alu_arb_rsp u_rsp (
            .clk    (clk),
            .rst_n  (rst_n),
            .cap    (cap[g]),
            .ready  (rrdy[g]),
            .res_d  (alu_result),
            .less_d (less_cap),
            .zero_d (alu_zero),
            .valid  (rv[g]),
            .result (rres[g]),
            .less   (rl[g]),
            .zero   (rz[g])
        );
    end

    assign rsp0_valid  = rv[0];
    assign rsp0_result = rres[0];
    assign rsp0_less   = rl[0];
    assign rsp0_zero   = rz[0];
    assign rsp1_valid  = rv[1];
    assign rsp1_result = rres[1];
    assign rsp1_less   = rl[1];
    assign rsp1_zero   = rz[1];
endmodule
